// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared types for the RV32M divide unit.
//   div_op_t    : operation select, equal to func3[1:0] of the OP/M instruction
//   div_state_t : divider sequencing states
// Helpers decode which operations are signed and which return the remainder.
// The multiplier keeps its own mul_ctrl encoding; nothing here touches it.
// ---------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_t;

  // func3[0] clear means a signed operation (DIV, REM)
  function automatic logic op_is_signed(input div_op_t op);
    logic [1:0] code;
    code = op;
    return ~code[0];
  endfunction

  // func3[1] set means the remainder is the architectural result
  function automatic logic op_wants_rem(input div_op_t op);
    logic [1:0] code;
    code = op;
    return code[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
// Ports:
//   rem      in  DATA_WIDTH  partial remainder before this step
//   quo      in  DATA_WIDTH  dividend bits still to shift in / quotient so far
//   divisor  in  DATA_WIDTH  divisor magnitude
//   rem_next out DATA_WIDTH  partial remainder after this step
//   quo_next out DATA_WIDTH  quotient register after this step
// ---------------------------------------------------------------------------
import div_pkg::*;

module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic [DATA_WIDTH-1:0] quo,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic [DATA_WIDTH-1:0] quo_next
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] diff;
  logic                fits;

  // The shifted remainder needs one extra bit: rem < divisor on entry, so
  // 2*rem+1 can exceed DATA_WIDTH bits but always fits in DATA_WIDTH+1.
  always_comb begin
    shifted  = {rem, quo[DATA_WIDTH-1]};
    diff     = shifted - {1'b0, divisor};
    fits     = (shifted >= {1'b0, divisor});
    rem_next = fits ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
    quo_next = {quo[DATA_WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div.sv
// ---------------------------------------------------------------------------
// div
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// The core pulses start for one cycle, stalls while busy is high and takes
// result on the done pulse. Divide-by-zero and signed overflow finish in one
// cycle without iterating.
// Build option: define DIV_EARLY_OUT_EN to also finish in one cycle when the
// dividend magnitude is below a nonzero divisor magnitude (same results,
// shorter latency).
// Ports:
//   clk      in  1           clock, rising edge
//   rst_n    in  1           asynchronous active-low reset
//   start    in  1           launch request, sampled only in IDLE
//   a        in  DATA_WIDTH  dividend (rs1)
//   b        in  DATA_WIDTH  divisor (rs2)
//   div_ctrl in  2           func3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   busy     out 1           operation in flight (CALC and DONE)
//   done     out 1           one-cycle pulse, result valid in that cycle
//   result   out DATA_WIDTH  quotient or remainder, held until the next done
// ---------------------------------------------------------------------------
import div_pkg::*;

module div #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [1:0]            div_ctrl,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_t state, state_next;

  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [DATA_WIDTH-1:0] divisor_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  neg_q;
  logic                  neg_r;
  div_op_t               op_q;

  div_op_t               op_in;
  logic                  signed_op;
  logic                  a_neg;
  logic                  b_neg;
  logic [DATA_WIDTH-1:0] a_mag;
  logic [DATA_WIDTH-1:0] b_mag;
  logic                  div_zero;
  logic                  overflow;
  logic                  early_out;
  logic                  special_case;

  logic [DATA_WIDTH-1:0] step_rem;
  logic [DATA_WIDTH-1:0] step_quo;
  logic [DATA_WIDTH-1:0] quo_fixed;
  logic [DATA_WIDTH-1:0] rem_fixed;
  logic [DATA_WIDTH-1:0] final_value;

  // Operand conditioning for an incoming request: magnitudes for the signed
  // ops and detection of the cases that bypass the iteration. The most
  // negative value keeps its own bit pattern as magnitude, which is correct
  // when read as unsigned.
  always_comb begin
    op_in     = div_op_t'(div_ctrl);
    signed_op = op_is_signed(op_in);
    a_neg     = signed_op & a[DATA_WIDTH-1];
    b_neg     = signed_op & b[DATA_WIDTH-1];
    a_mag     = a_neg ? (~a + ONE) : a;
    b_mag     = b_neg ? (~b + ONE) : b;
    div_zero  = (b == '0);
    overflow  = signed_op & (a == MOST_NEG) & (b == ALL_ONES);
`ifdef DIV_EARLY_OUT_EN
    early_out = (b != '0) & (a_mag < b_mag);
`else
    early_out = 1'b0;
`endif
    special_case = div_zero | overflow | early_out;
  end

  div_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Sign fix-up and result selection. Bypass cases load their final values
  // with both negate flags cleared, so they pass through unchanged.
  always_comb begin
    quo_fixed   = neg_q ? (~quo_q + ONE) : quo_q;
    rem_fixed   = neg_r ? (~rem_q + ONE) : rem_q;
    final_value = op_wants_rem(op_q) ? rem_fixed : quo_fixed;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control outputs. Busy stays high through the DONE cycle
  // so the core never issues a start that would be dropped there.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    result     = result_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = special_case ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (count == CNT_ONE) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        result     = final_value;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers. An accepted start captures everything the operation
  // needs, so later changes on a/b/div_ctrl cannot disturb it. Bypass cases
  // preload quotient/remainder with their architectural answers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      op_q      <= DIV;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q      <= op_in;
            count     <= CNT_LOAD;
            divisor_q <= b_mag;
            if (div_zero) begin
              quo_q <= ALL_ONES;
              rem_q <= a;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else if (overflow) begin
              quo_q <= a;
              rem_q <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else if (early_out) begin
              quo_q <= '0;
              rem_q <= a;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              quo_q <= a_mag;
              rem_q <= '0;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
            end
          end
        end
        CALC: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          count <= count - CNT_ONE;
        end
        DONE: begin
          result_q <= final_value;
        end
        default: begin
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/div.md
Name: div

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Companion to the combinational multiplier in the execute stage; it covers the divide half of the M extension.
- Multi-cycle: the core raises a one-cycle start, stalls while busy is high, and captures result on the done pulse.
- Operation select is func3[1:0] of the OP/M instruction.

Parameters:
- DATA_WIDTH, 32, operand and result width in bits.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  launch request; sampled only in IDLE.
- a  in  DATA_WIDTH  dividend (rs1).
- b  in  DATA_WIDTH  divisor (rs2).
- div_ctrl  in  2  func3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle pulse; result valid in the same cycle.
- result  out  DATA_WIDTH  quotient or remainder; holds its value until the next done.

Behaviour:
- Reset: one clock, asynchronous, active-low. While rst_n=0: state=IDLE, busy=0, done=0, result=0, and all internal registers are 0. Reset asserted mid-operation aborts the operation with no done pulse.
- State machine: IDLE -> CALC -> DONE -> IDLE.
- IDLE:
  - On start=1, register a, b and div_ctrl.
  - Signed ops (DIV, REM): register |a| and |b|, plus neg_q = a[MSB]^b[MSB] and neg_r = a[MSB].
  - Load counter = DATA_WIDTH. Go to CALC, or straight to DONE on a special case.
- CALC: one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - If rem >= divisor magnitude: subtract it and set quo[0]=1.
  - Decrement the counter; at 0, go to DONE.
  - Subtraction width is DATA_WIDTH+1 bits to hold the carry.
- DONE:
  - Apply sign fix: quotient negated if neg_q, remainder negated if neg_r.
  - Select quotient (div_ctrl[1]=0) or remainder (div_ctrl[1]=1).
  - Drive result, pulse done for one cycle, clear busy, return to IDLE.
- Latency, normal case: start in cycle 0, done in cycle DATA_WIDTH+1 (33 for the default).
- Latency, special cases: done in cycle 1.
- Special cases, decided in IDLE and skipping CALC:
  - b==0, any op: quotient = all ones, remainder = a.
  - Signed overflow (a=most-negative, b=all ones, DIV/REM): quotient = a, remainder = 0.
- start while busy=1 or in DONE: ignored, with no effect on the operation in flight.
- a/b/div_ctrl changes after acceptance: no effect, because operands are registered.
- Back-to-back: start may be asserted in the cycle after done; it is accepted.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if the unsigned dividend magnitude < divisor magnitude (divisor nonzero), skip CALC. Quotient = 0, remainder = original a; done in cycle 1.
- Undefined: that case runs the full DATA_WIDTH iterations and gives the identical result.
- Result values never differ between the two builds; only latency differs.

Decomposition:
- Shared package div_pkg:
  - Enum div_op_t with DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11.
  - State enum div_state_t with IDLE, CALC, DONE.
- The multiplier's mul_ctrl encoding stays in that module and is unchanged.
- One natural sub-module: div_step, a combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem and next quo.
- The top level holds the FSM, counter, sign handling and special cases.

Test Plan:
- DIVU a=100, b=7 -> done at cycle 33, result=14. Then REMU with the same operands -> result=2.
- DIV a=-7 (0xFFFFFFF9), b=2 -> result=0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1); the remainder takes the dividend's sign.
- Divide by zero, DIV a=5, b=0 -> done at cycle 1, result=0xFFFFFFFF. REMU a=5, b=0 -> result=5.
- Signed overflow, DIV a=0x80000000, b=0xFFFFFFFF -> result=0x80000000 at cycle 1. REM with the same operands -> result=0.
- start re-asserted with new operands at cycle 10 of a DIVU 100/7 -> ignored, result=14. Second start in the cycle after done -> accepted.
- rst_n low at cycle 15 of an operation -> busy=0, done=0, result=0 immediately; no done pulse. After release, a new operation completes correctly.
- With DIV_EARLY_OUT_EN defined: DIVU 3/10 -> result=0 at cycle 1, and REMU 3/10 -> 3. With the macro undefined, the same results arrive at cycle 33.
